// File: rtl/serial_link_axi_rx_fifo.sv
// AXI4 write-terminating subordinate that buffers every W beat in a FIFO,
// drained by an OBI reader port; reads are always answered with SLVERR.
module serial_link_axi_rx_fifo #(
  parameter int unsigned FifoDepth  = 8,
  parameter int unsigned IdWidth    = 4,
  parameter int unsigned AddrWidth  = 32,
  parameter int unsigned DataWidth  = 32,
  localparam int unsigned PtrWidth   = $clog2(FifoDepth),
  localparam int unsigned UsageWidth = $clog2(FifoDepth) + 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   aw_valid_i,
  output logic                   aw_ready_o,
  input  logic [IdWidth-1:0]     aw_id_i,
  input  logic [AddrWidth-1:0]   aw_addr_i,
  input  logic [7:0]             aw_len_i,
  input  logic                   w_valid_i,
  output logic                   w_ready_o,
  input  logic [DataWidth-1:0]   w_data_i,
  input  logic [DataWidth/8-1:0] w_strb_i,
  input  logic                   w_last_i,
  output logic                   b_valid_o,
  input  logic                   b_ready_i,
  output logic [IdWidth-1:0]     b_id_o,
  output logic [1:0]             b_resp_o,
  input  logic                   ar_valid_i,
  output logic                   ar_ready_o,
  input  logic [IdWidth-1:0]     ar_id_i,
  input  logic [7:0]             ar_len_i,
  output logic                   r_valid_o,
  input  logic                   r_ready_i,
  output logic [IdWidth-1:0]     r_id_o,
  output logic [DataWidth-1:0]   r_data_o,
  output logic [1:0]             r_resp_o,
  output logic                   r_last_o,
  input  logic                   reader_req_i,
  output logic                   reader_gnt_o,
  input  logic [AddrWidth-1:0]   reader_addr_i,
  input  logic                   reader_we_i,
  input  logic [DataWidth/8-1:0] reader_be_i,
  input  logic [DataWidth-1:0]   reader_wdata_i,
  output logic                   reader_rvalid_o,
  output logic [DataWidth-1:0]   reader_rdata_o,
  output logic                   fifo_empty_o,
  output logic                   fifo_full_o,
  output logic [UsageWidth-1:0]  fifo_usage_o
);

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_RESP} r_state_e;

  w_state_e             w_state_q, w_state_d;
  logic [IdWidth-1:0]   w_id_q, w_id_d;
  logic [7:0]           w_len_q, w_len_d;
  logic [7:0]           w_cnt_q, w_cnt_d;
  logic                 w_err_q, w_err_d;
  logic [1:0]           b_resp_q, b_resp_d;

  r_state_e             r_state_q, r_state_d;
  logic [IdWidth-1:0]   r_id_q, r_id_d;
  logic [7:0]           r_len_q, r_len_d;
  logic [7:0]           r_cnt_q, r_cnt_d;

  logic [DataWidth-1:0] mem_q [FifoDepth];
  logic [DataWidth-1:0] mem_d [FifoDepth];
  logic [PtrWidth-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrWidth-1:0]  rd_ptr_q, rd_ptr_d;
  logic [UsageWidth-1:0] usage_q, usage_d;
  logic                 rvalid_q, rvalid_d;
  logic [DataWidth-1:0] rdata_q, rdata_d;

  logic                 push, pop, fifo_full, fifo_empty;
  logic [DataWidth-1:0] w_data_masked;
  logic [DataWidth-1:0] status_word;

  logic unused_inputs;
  assign unused_inputs = ^{aw_addr_i, reader_addr_i, reader_be_i, reader_wdata_i};

  assign fifo_full  = (usage_q == UsageWidth'(FifoDepth));
  assign fifo_empty = (usage_q == '0);

  // Bytes with a cleared strobe are stored as zero rather than left stale.
  always_comb begin
    w_data_masked = '0;
    for (int i = 0; i < DataWidth / 8; i++) begin
      if (w_strb_i[i]) begin
        w_data_masked[8*i +: 8] = w_data_i[8*i +: 8];
      end
    end
  end

  always_comb begin
    w_state_d  = w_state_q;
    w_id_d     = w_id_q;
    w_len_d    = w_len_q;
    w_cnt_d    = w_cnt_q;
    w_err_d    = w_err_q;
    b_resp_d   = b_resp_q;
    aw_ready_o = 1'b0;
    w_ready_o  = 1'b0;
    b_valid_o  = 1'b0;
    push       = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        aw_ready_o = 1'b1;
        if (aw_valid_i) begin
          w_id_d    = aw_id_i;
          w_len_d   = aw_len_i;
          w_cnt_d   = '0;
          w_err_d   = 1'b0;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        w_ready_o = !fifo_full;
        if (w_valid_i && !fifo_full) begin
          push    = 1'b1;
          w_cnt_d = w_cnt_q + 8'd1;
          // The burst length from AW decides the end; an early last only poisons the response.
          if (w_cnt_q == w_len_q) begin
            b_resp_d  = (w_last_i && !w_err_q) ? RespOkay : RespSlvErr;
            w_state_d = W_RESP;
          end else if (w_last_i) begin
            w_err_d = 1'b1;
          end
        end
      end
      W_RESP: begin
        b_valid_o = 1'b1;
        if (b_ready_i) begin
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  assign b_id_o   = w_id_q;
  assign b_resp_o = b_resp_q;

  always_comb begin
    r_state_d  = r_state_q;
    r_id_d     = r_id_q;
    r_len_d    = r_len_q;
    r_cnt_d    = r_cnt_q;
    ar_ready_o = 1'b0;
    r_valid_o  = 1'b0;
    r_resp_o   = RespOkay;
    r_last_o   = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        ar_ready_o = 1'b1;
        if (ar_valid_i) begin
          r_id_d    = ar_id_i;
          r_len_d   = ar_len_i;
          r_cnt_d   = '0;
          r_state_d = R_RESP;
        end
      end
      R_RESP: begin
        r_valid_o = 1'b1;
        r_resp_o  = RespSlvErr;
        r_last_o  = (r_cnt_q == r_len_q);
        if (r_ready_i) begin
          if (r_cnt_q == r_len_q) begin
            r_state_d = R_IDLE;
          end else begin
            r_cnt_d = r_cnt_q + 8'd1;
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  assign r_id_o   = r_id_q;
  assign r_data_o = '0;

  assign status_word = {{(DataWidth-2-UsageWidth){1'b0}}, usage_q, fifo_full, fifo_empty};

  // OBI reader: every request is granted; the response is registered one cycle later.
  always_comb begin
    pop      = 1'b0;
    rvalid_d = reader_req_i;
    rdata_d  = '0;
    if (reader_req_i && !reader_we_i) begin
      if (reader_addr_i[2]) begin
        rdata_d = status_word;
      end else if (!fifo_empty) begin
        pop     = 1'b1;
        rdata_d = mem_q[rd_ptr_q];
      end
    end
  end

  assign reader_gnt_o    = reader_req_i;
  assign reader_rvalid_o = rvalid_q;
  assign reader_rdata_o  = rdata_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    usage_d  = usage_q;
    if (push) begin
      mem_d[wr_ptr_q] = w_data_masked;
      wr_ptr_d        = wr_ptr_q + PtrWidth'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrWidth'(1);
    end
    case ({push, pop})
      2'b10:   usage_d = usage_q + UsageWidth'(1);
      2'b01:   usage_d = usage_q - UsageWidth'(1);
      default: usage_d = usage_q;
    endcase
  end

  assign fifo_empty_o = fifo_empty;
  assign fifo_full_o  = fifo_full;
  assign fifo_usage_o = usage_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      w_state_q <= W_IDLE;
      w_id_q    <= '0;
      w_len_q   <= '0;
      w_cnt_q   <= '0;
      w_err_q   <= 1'b0;
      b_resp_q  <= '0;
      r_state_q <= R_IDLE;
      r_id_q    <= '0;
      r_len_q   <= '0;
      r_cnt_q   <= '0;
      mem_q     <= '{default: '0};
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      usage_q   <= '0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      w_state_q <= w_state_d;
      w_id_q    <= w_id_d;
      w_len_q   <= w_len_d;
      w_cnt_q   <= w_cnt_d;
      w_err_q   <= w_err_d;
      b_resp_q  <= b_resp_d;
      r_state_q <= r_state_d;
      r_id_q    <= r_id_d;
      r_len_q   <= r_len_d;
      r_cnt_q   <= r_cnt_d;
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      usage_q   <= usage_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
    end
  end

endmodule

// File: tb/tb_serial_link_axi_rx_fifo.sv
// Scoreboard bench for serial_link_axi_rx_fifo: a queue-based reference model
// predicts FIFO contents, flags, B/R responses and OBI read data.
module tb_serial_link_axi_rx_fifo;

  localparam int Depth   = 8;
  localparam int UsageW  = $clog2(Depth) + 1;
  localparam int Timeout = 300;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        aw_valid_i, aw_ready_o;
  logic [3:0]  aw_id_i;
  logic [31:0] aw_addr_i;
  logic [7:0]  aw_len_i;
  logic        w_valid_i, w_ready_o;
  logic [31:0] w_data_i;
  logic [3:0]  w_strb_i;
  logic        w_last_i;
  logic        b_valid_o, b_ready_i;
  logic [3:0]  b_id_o;
  logic [1:0]  b_resp_o;
  logic        ar_valid_i, ar_ready_o;
  logic [3:0]  ar_id_i;
  logic [7:0]  ar_len_i;
  logic        r_valid_o, r_ready_i;
  logic [3:0]  r_id_o;
  logic [31:0] r_data_o;
  logic [1:0]  r_resp_o;
  logic        r_last_o;
  logic        reader_req_i, reader_gnt_o;
  logic [31:0] reader_addr_i;
  logic        reader_we_i;
  logic [3:0]  reader_be_i;
  logic [31:0] reader_wdata_i;
  logic        reader_rvalid_o;
  logic [31:0] reader_rdata_o;
  logic        fifo_empty_o, fifo_full_o;
  logic [UsageW-1:0] fifo_usage_o;

  int compared = 0;
  int mismatched = 0;

  serial_link_axi_rx_fifo #(.FifoDepth(Depth), .IdWidth(4), .AddrWidth(32), .DataWidth(32)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o), .aw_id_i(aw_id_i),
    .aw_addr_i(aw_addr_i), .aw_len_i(aw_len_i),
    .w_valid_i(w_valid_i), .w_ready_o(w_ready_o), .w_data_i(w_data_i),
    .w_strb_i(w_strb_i), .w_last_i(w_last_i),
    .b_valid_o(b_valid_o), .b_ready_i(b_ready_i), .b_id_o(b_id_o), .b_resp_o(b_resp_o),
    .ar_valid_i(ar_valid_i), .ar_ready_o(ar_ready_o), .ar_id_i(ar_id_i), .ar_len_i(ar_len_i),
    .r_valid_o(r_valid_o), .r_ready_i(r_ready_i), .r_id_o(r_id_o), .r_data_o(r_data_o),
    .r_resp_o(r_resp_o), .r_last_o(r_last_o),
    .reader_req_i(reader_req_i), .reader_gnt_o(reader_gnt_o), .reader_addr_i(reader_addr_i),
    .reader_we_i(reader_we_i), .reader_be_i(reader_be_i), .reader_wdata_i(reader_wdata_i),
    .reader_rvalid_o(reader_rvalid_o), .reader_rdata_o(reader_rdata_o),
    .fifo_empty_o(fifo_empty_o), .fifo_full_o(fifo_full_o), .fifo_usage_o(fifo_usage_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed { logic [3:0] id; logic [1:0] resp; } b_exp_t;
  typedef struct packed { logic [3:0] id; logic last; } r_exp_t;

  logic [31:0] model_fifo[$];
  logic [31:0] obi_exp_q[$];
  b_exp_t      b_exp_q[$];
  r_exp_t      r_exp_q[$];

  logic [31:0] wr_data[256];
  logic [3:0]  wr_strb[256];
  logic        wr_last[256];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: protocol phases and FIFO contents derived from bus traffic.
  int         m_wphase = 0, m_rphase = 0;
  logic [3:0] m_wid;
  int         m_wlen, m_wbeat, m_rleft;
  bit         m_early;

  always @(negedge clk_i) begin : model
    int sz;
    logic [31:0] exp_rd;
    logic [31:0] mask;
    if (!rst_ni) begin
      model_fifo.delete(); obi_exp_q.delete(); b_exp_q.delete(); r_exp_q.delete();
      m_wphase = 0; m_rphase = 0;
    end else begin
      sz = model_fifo.size();
      checkOutput("fifo_usage", fifo_usage_o, sz);
      checkOutput("fifo_empty", fifo_empty_o, sz == 0);
      checkOutput("fifo_full", fifo_full_o, sz == Depth);
      checkOutput("aw_ready", aw_ready_o, m_wphase == 0);
      checkOutput("w_ready", w_ready_o, m_wphase == 1 && sz < Depth);
      checkOutput("b_valid", b_valid_o, m_wphase == 2);
      checkOutput("ar_ready", ar_ready_o, m_rphase == 0);
      checkOutput("r_valid", r_valid_o, m_rphase == 1);
      checkOutput("reader_gnt", reader_gnt_o, reader_req_i);
      if (reader_req_i) begin
        if (reader_we_i) exp_rd = 32'h0;
        else if (reader_addr_i[2])
          exp_rd = (32'(sz) << 2) + ((sz == Depth) ? 32'd2 : 32'd0) + ((sz == 0) ? 32'd1 : 32'd0);
        else if (sz > 0) exp_rd = model_fifo.pop_front();
        else exp_rd = 32'h0;
        obi_exp_q.push_back(exp_rd);
      end
      case (m_wphase)
        0: if (aw_valid_i) begin
          m_wid = aw_id_i; m_wlen = int'(aw_len_i); m_wbeat = 0; m_early = 0; m_wphase = 1;
        end
        1: if (w_valid_i && sz < Depth) begin
          mask = {{8{w_strb_i[3]}}, {8{w_strb_i[2]}}, {8{w_strb_i[1]}}, {8{w_strb_i[0]}}};
          model_fifo.push_back(w_data_i & mask);
          if (m_wbeat == m_wlen) begin
            b_exp_q.push_back('{id: m_wid, resp: (!m_early && w_last_i) ? 2'b00 : 2'b10});
            m_wphase = 2;
          end else begin
            if (w_last_i) m_early = 1;
            m_wbeat++;
          end
        end
        default: if (b_ready_i) m_wphase = 0;
      endcase
      if (m_rphase == 0) begin
        if (ar_valid_i) begin
          for (int k = 0; k <= int'(ar_len_i); k++)
            r_exp_q.push_back('{id: ar_id_i, last: (k == int'(ar_len_i))});
          m_rleft = int'(ar_len_i) + 1;
          m_rphase = 1;
        end
      end else if (r_ready_i) begin
        m_rleft--;
        if (m_rleft == 0) m_rphase = 0;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents a response.
  always @(negedge clk_i) begin : monitor
    logic [31:0] e;
    b_exp_t be;
    r_exp_t re;
    if (rst_ni) begin
      if (reader_rvalid_o) begin
        if (obi_exp_q.size() == 0) checkOutput("reader_rvalid_unexpected", 1, 0);
        else begin e = obi_exp_q.pop_front(); checkOutput("reader_rdata", reader_rdata_o, e); end
      end
      if (b_valid_o && b_ready_i) begin
        if (b_exp_q.size() == 0) checkOutput("b_unexpected", 1, 0);
        else begin
          be = b_exp_q.pop_front();
          checkOutput("b_id", b_id_o, be.id);
          checkOutput("b_resp", b_resp_o, be.resp);
        end
      end
      if (r_valid_o && r_ready_i) begin
        if (r_exp_q.size() == 0) checkOutput("r_unexpected", 1, 0);
        else begin
          re = r_exp_q.pop_front();
          checkOutput("r_id", r_id_o, re.id);
          checkOutput("r_data", r_data_o, 0);
          checkOutput("r_resp", r_resp_o, 2'b10);
          checkOutput("r_last", r_last_o, re.last);
        end
      end
    end
  end

  task automatic waitCycle();
    @(posedge clk_i); #1;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_aw_ready"}, aw_ready_o, 1);
    checkOutput({tag, "_ar_ready"}, ar_ready_o, 1);
    checkOutput({tag, "_w_ready"}, w_ready_o, 0);
    checkOutput({tag, "_b_valid"}, b_valid_o, 0);
    checkOutput({tag, "_r_valid"}, r_valid_o, 0);
    checkOutput({tag, "_r_last"}, r_last_o, 0);
    checkOutput({tag, "_ids_resps"}, {b_id_o, r_id_o, b_resp_o, r_resp_o}, 0);
    checkOutput({tag, "_r_data"}, r_data_o, 0);
    checkOutput({tag, "_reader_rvalid"}, reader_rvalid_o, 0);
    checkOutput({tag, "_reader_rdata"}, reader_rdata_o, 0);
    checkOutput({tag, "_flags"}, {fifo_empty_o, fifo_full_o}, 2'b10);
    checkOutput({tag, "_usage"}, fifo_usage_o, 0);
  endtask

  task automatic writeBurst(input logic [3:0] id, input int len, input bit gaps);
    int t;
    bit ok;
    aw_valid_i = 1; aw_id_i = id; aw_len_i = 8'(len); aw_addr_i = $urandom;
    t = 0; ok = 0;
    while (!ok && t < Timeout) begin @(negedge clk_i); ok = aw_ready_o; t++; end
    waitCycle(); aw_valid_i = 0;
    if (!ok) begin checkOutput("aw_handshake_timeout", 0, 1); return; end
    for (int b = 0; b <= len; b++) begin
      if (gaps) repeat ($urandom_range(0, 2)) waitCycle();
      w_valid_i = 1; w_data_i = wr_data[b]; w_strb_i = wr_strb[b]; w_last_i = wr_last[b];
      t = 0; ok = 0;
      while (!ok && t < Timeout) begin @(negedge clk_i); ok = w_ready_o; t++; end
      waitCycle(); w_valid_i = 0; w_last_i = 0;
      if (!ok) begin checkOutput("w_handshake_timeout", 0, 1); return; end
    end
    if (gaps) repeat ($urandom_range(0, 2)) waitCycle();
    b_ready_i = 1;
    t = 0; ok = 0;
    while (!ok && t < Timeout) begin @(negedge clk_i); ok = b_valid_o; t++; end
    waitCycle(); b_ready_i = 0;
    if (!ok) checkOutput("b_handshake_timeout", 0, 1);
  endtask

  task automatic readBurst(input logic [3:0] id, input int len);
    int t;
    bit ok;
    ar_valid_i = 1; ar_id_i = id; ar_len_i = 8'(len);
    t = 0; ok = 0;
    while (!ok && t < Timeout) begin @(negedge clk_i); ok = ar_ready_o; t++; end
    waitCycle(); ar_valid_i = 0;
    if (!ok) begin checkOutput("ar_handshake_timeout", 0, 1); return; end
    t = 0; ok = 0;
    while (!ok && t < Timeout) begin
      r_ready_i = 1'($urandom_range(0, 1));
      @(negedge clk_i);
      ok = r_valid_o && r_ready_i && r_last_o;
      t++;
      if (!ok) begin @(posedge clk_i); #1; end
    end
    waitCycle(); r_ready_i = 0;
    if (!ok) checkOutput("r_last_timeout", 0, 1);
  endtask

  task automatic obiRead(input logic [31:0] addr);
    reader_req_i = 1; reader_addr_i = addr; reader_we_i = 0;
    waitCycle();
    reader_req_i = 0;
  endtask

  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) begin
      wr_data[i] = $urandom; wr_strb[i] = 4'hF; wr_last[i] = 1;
    end
  endtask

  bit w_done;

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    aw_valid_i = 0; aw_id_i = 0; aw_addr_i = 0; aw_len_i = 0;
    w_valid_i = 0; w_data_i = 0; w_strb_i = 0; w_last_i = 0; b_ready_i = 0;
    ar_valid_i = 0; ar_id_i = 0; ar_len_i = 0; r_ready_i = 0;
    reader_req_i = 0; reader_addr_i = 0; reader_we_i = 0; reader_be_i = 0; reader_wdata_i = 0;
    rst_ni = 1;
    #1 rst_ni = 0;
    #1 checkResetValues("reset");
    repeat (2) waitCycle();
    rst_ni = 1;
    waitCycle();

    $display("[TB] single beat write and OBI readback");
    wr_data[0] = 32'hA5A5_0001; wr_strb[0] = 4'hF; wr_last[0] = 1;
    writeBurst(4'd3, 0, 0);
    obiRead(32'h0);
    obiRead(32'h4);
    repeat (2) waitCycle();

    $display("[TB] four beat burst with partial strobe");
    wr_data[0] = 32'h10; wr_data[1] = 32'hDEAD_0011; wr_data[2] = 32'h12; wr_data[3] = 32'h13;
    wr_strb[0] = 4'hF; wr_strb[1] = 4'h3; wr_strb[2] = 4'hF; wr_strb[3] = 4'hF;
    wr_last[0] = 0; wr_last[1] = 0; wr_last[2] = 0; wr_last[3] = 1;
    writeBurst(4'd1, 3, 0);
    checkOutput("usage_after_burst", fifo_usage_o, 4);
    for (int i = 0; i < 5; i++) obiRead(32'h0);
    waitCycle();

    $display("[TB] fill to full, then pop releases backpressure");
    for (int i = 0; i < Depth; i++) begin
      applyStimulus(1);
      writeBurst(4'(i), 0, 0);
    end
    checkOutput("full_after_fill", fifo_full_o, 1);
    applyStimulus(1);
    fork
      writeBurst(4'd9, 0, 0);
      begin
        repeat (4) waitCycle();
        checkOutput("w_ready_while_full", w_ready_o, 0);
        obiRead(32'h0);
      end
    join
    for (int i = 0; i < Depth + 1; i++) obiRead(32'h0);
    waitCycle();

    $display("[TB] early last gives SLVERR");
    applyStimulus(2);
    writeBurst(4'd2, 1, 0);
    for (int i = 0; i < 3; i++) obiRead(32'h0);

    $display("[TB] concurrent read and write bursts");
    applyStimulus(3);
    fork
      readBurst(4'd5, 2);
      writeBurst(4'd6, 2, 1);
    join
    for (int i = 0; i < 4; i++) obiRead(32'h0);
    obiRead(32'h4);
    checkOutput("usage_empty_read", fifo_usage_o, 0);
    waitCycle();

    $display("[TB] reset during W_DATA");
    aw_valid_i = 1; aw_id_i = 4'd7; aw_len_i = 8'd3;
    waitCycle();
    aw_valid_i = 0; w_valid_i = 1; w_data_i = 32'h55; w_strb_i = 4'hF; w_last_i = 0;
    repeat (2) waitCycle();
    rst_ni = 0; w_valid_i = 0; b_ready_i = 1;
    #1 checkResetValues("midburst_reset");
    repeat (2) waitCycle();
    rst_ni = 1;
    repeat (4) waitCycle();
    b_ready_i = 0;

    $display("[TB] randomized traffic");
    w_done = 0;
    fork
      begin
        for (int n = 0; n < 20; n++) begin
          int len, mode;
          len = $urandom_range(0, 4);
          mode = $urandom_range(0, 3);
          for (int b = 0; b <= len; b++) begin
            wr_data[b] = $urandom; wr_strb[b] = 4'($urandom);
            wr_last[b] = (mode == 3) ? 1'b0 : (b == len);
          end
          if (mode == 2) wr_last[$urandom_range(0, len)] = 1;
          writeBurst(4'($urandom), len, 1);
        end
        w_done = 1;
      end
      begin
        for (int n = 0; n < 8; n++) begin
          readBurst(4'($urandom), $urandom_range(0, 3));
          repeat ($urandom_range(0, 3)) waitCycle();
        end
      end
      begin
        while (!w_done) begin
          reader_req_i = 1'($urandom_range(0, 1));
          reader_addr_i = ($urandom & ~32'h4) | ($urandom_range(0, 3) == 0 ? 32'h4 : 32'h0);
          reader_we_i = ($urandom_range(0, 7) == 0);
          reader_be_i = 4'($urandom); reader_wdata_i = $urandom;
          waitCycle();
        end
        reader_req_i = 0; reader_we_i = 0;
      end
    join
    for (int i = 0; i < Depth + 1; i++) obiRead(32'h0);
    repeat (4) waitCycle();
    checkOutput("obi_expect_leftover", obi_exp_q.size(), 0);
    checkOutput("b_expect_leftover", b_exp_q.size(), 0);
    checkOutput("r_expect_leftover", r_exp_q.size(), 0);
    checkOutput("final_empty", fifo_empty_o, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
